gate_sweep_checker: RTL and testbench

Self-checking response side for small combinational gates. The stimulus side drives gate inputs and prints results. This block generates every input combination for a gate under test and holds each one until the gate settles. It then samples the gate output, compares it with a selectable reference function, and reports an error count, the first failing vector and a pass flag. It sits next to any 1..8-input gate (Or_gate and similar) as an on-chip exerciser.

---
 rtl/gate_check_pkg.sv | 11 +
 rtl/gate_ref_model.sv | 23 ++
 rtl/gate_sweep_checker.sv | 136 +++++++++++++
 tb/tb_gate_sweep_checker.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_check_pkg.sv
// Shared encodings for the gate sweep checker: reference function codes and FSM states.
package gate_check_pkg;

    localparam logic [1:0] FN_OR  = 2'b00;
    localparam logic [1:0] FN_AND = 2'b01;
    localparam logic [1:0] FN_XOR = 2'b10;
    localparam logic [1:0] FN_NOR = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for a reduction gate: OR, AND, XOR or NOR over all stim bits.
module gate_ref_model
    import gate_check_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [1:0]      func,
    input  logic [N_IN-1:0] stim,
    output logic            expected
);

    always_comb begin
        expected = 1'b0;
        case (func)
            FN_OR:   expected = |stim;
            FN_AND:  expected = &stim;
            FN_XOR:  expected = ^stim;
            FN_NOR:  expected = ~|stim;
            default: expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive input sweep for a small gate: holds each vector SETTLE+1 cycles, samples
// the gate on the last hold cycle and tallies mismatches against the reference model.
module gate_sweep_checker
    import gate_check_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       func,
    output logic [N_IN-1:0]  stim,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [N_IN-1:0]  first_err_vec
);

    localparam logic [3:0]       HOLD_LAST = 4'(SETTLE);
    localparam logic [N_IN-1:0]  STIM_MAX  = '1;
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic [3:0]        hold_q, hold_d;
    logic [1:0]        func_q, func_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              fev_q, fev_d;
    logic [N_IN-1:0]   fvec_q, fvec_d;
    logic              pass_q, pass_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              expected;
    logic              mismatch;

    gate_ref_model #(.N_IN(N_IN)) u_ref (
        .func     (func_q),
        .stim     (stim_q),
        .expected (expected)
    );

    assign mismatch = (dut_out != expected);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stim_q  <= '0;
            hold_q  <= '0;
            func_q  <= FN_OR;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fvec_q  <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            hold_q  <= hold_d;
            func_q  <= func_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fvec_q  <= fvec_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        hold_d  = hold_q;
        func_d  = func_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fvec_d  = fvec_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    stim_d  = '0;
                    hold_d  = '0;
                    func_d  = func;
                    err_d   = '0;
                    fev_d   = 1'b0;
                    fvec_d  = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (hold_q == HOLD_LAST) begin
                    if (mismatch) begin
                        if (err_q != ERR_MAX) err_d = err_q + 1'b1;
                        if (!fev_q) begin
                            fev_d  = 1'b1;
                            fvec_d = stim_q;
                        end
                    end
                    if (stim_q == STIM_MAX) begin
                        // Final sample folds into pass here; saturation keeps err nonzero.
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pass_d  = !mismatch && (err_q == '0);
                    end else begin
                        stim_d = stim_q + 1'b1;
                        hold_d = '0;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign stim            = stim_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_q;
    assign first_err_valid = fev_q;
    assign first_err_vec   = fvec_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench: two checker instances (2-input/8-bit count, 3-input/2-bit count) driving
// modelled gates; a queue of predicted sweep results is checked at each done pulse.
module tb_gate_sweep_checker;
    import gate_check_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n  = 1'b0;
    logic       start1 = 1'b0, start2 = 1'b0;
    logic [1:0] func1 = FN_OR, func2 = FN_OR;
    int         mode1 = 0, mode2 = 0;

    logic [1:0] s1;  logic o1, busy1, done1, pass1, fev1; logic [7:0] err1; logic [1:0] fvec1;
    logic [2:0] s2;  logic o2, busy2, done2, pass2, fev2; logic [1:0] err2; logic [2:0] fvec2;

    gate_sweep_checker #(.N_IN(2), .SETTLE(2), .ERR_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .func(func1), .stim(s1), .dut_out(o1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_err_valid(fev1), .first_err_vec(fvec1));

    gate_sweep_checker #(.N_IN(3), .SETTLE(2), .ERR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .func(func2), .stim(s2), .dut_out(o2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .first_err_valid(fev2), .first_err_vec(fvec2));

    int errors = 0;
    int checks = 0;

    function automatic logic ref_fn(input logic [1:0] f, input logic [2:0] v, input int n);
        logic r;
        case (f)
            2'b00:   r = (n == 3) ? |v : |v[1:0];
            2'b01:   r = (n == 3) ? &v : &v[1:0];
            2'b10:   r = (n == 3) ? ^v : ^v[1:0];
            default: r = (n == 3) ? ~|v : ~|v[1:0];
        endcase
        return r;
    endfunction

    // Gate modes: 0 OR gate, 1 stuck-at-0, 2 XOR gate, 3 inverse of the reference.
    function automatic logic gate_fn(input int mode, input logic [1:0] f, input logic [2:0] v,
                                     input int n);
        case (mode)
            0:       return (n == 3) ? |v : |v[1:0];
            1:       return 1'b0;
            2:       return (n == 3) ? ^v : ^v[1:0];
            default: return !ref_fn(f, v, n);
        endcase
    endfunction

    always_comb o1 = gate_fn(mode1, func1, {1'b0, s1}, 2);
    always_comb o2 = gate_fn(mode2, func2, s2, 3);

    typedef struct {
        int   cnt;
        logic fv;
        int   vec;
        logic pass;
    } exp_t;
    exp_t sb[$];

    function automatic exp_t predict(input int mode, input logic [1:0] f, input int n,
                                     input int cap);
        exp_t e;
        logic [2:0] v;
        e.cnt = 0; e.fv = 1'b0; e.vec = 0;
        for (int k = 0; k < (1 << n); k++) begin
            v = 3'(k);
            if (gate_fn(mode, f, v, n) != ref_fn(f, v, n)) begin
                if (e.cnt < cap) e.cnt++;
                if (!e.fv) begin e.fv = 1'b1; e.vec = k; end
            end
        end
        e.pass = (e.cnt == 0);
        return e;
    endfunction

    int   sel = 1;
    logic o_busy, o_done, o_pass, o_fev;
    logic [31:0] o_stim, o_err, o_fvec;
    always_comb begin
        if (sel == 2) begin
            o_busy = busy2; o_done = done2; o_pass = pass2; o_fev = fev2;
            o_stim = 32'(s2); o_err = 32'(err2); o_fvec = 32'(fvec2);
        end else begin
            o_busy = busy1; o_done = done1; o_pass = pass1; o_fev = fev1;
            o_stim = 32'(s1); o_err = 32'(err1); o_fvec = 32'(fvec1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input int which, input string tag);
        sel = which;
        #1;
        chk({tag, "_stim"}, o_stim, 0);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_done"}, 32'(o_done), 0);
        chk({tag, "_pass"}, 32'(o_pass), 0);
        chk({tag, "_err"},  o_err, 0);
        chk({tag, "_fev"},  32'(o_fev), 0);
        chk({tag, "_fvec"}, o_fvec, 0);
    endtask

    // Called at the negedge where done is seen high.
    task automatic check_result(input int which, input string tag);
        exp_t e;
        int   smax;
        smax = (which == 2) ? 7 : 3;
        e = sb.pop_front();
        chk({tag, "_err"},  o_err, 32'(e.cnt));
        chk({tag, "_fev"},  32'(o_fev), 32'(e.fv));
        chk({tag, "_fvec"}, o_fvec, 32'(e.vec));
        chk({tag, "_pass"}, 32'(o_pass), 32'(e.pass));
        chk({tag, "_busy_at_done"}, 32'(o_busy), 0);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, 32'(o_done), 0);
        chk({tag, "_pass_held"}, 32'(o_pass), 32'(e.pass));
        chk({tag, "_stim_held"}, o_stim, 32'(smax));
    endtask

    task automatic run(input int which, input int mode, input logic [1:0] f, input string tag);
        int cycles;
        int lat;
        sel = which;
        lat = (which == 2) ? 24 : 12;
        sb.push_back(predict(mode, f, (which == 2) ? 3 : 2, (which == 2) ? 3 : 255));
        @(negedge clk);
        if (which == 2) begin mode2 = mode; func2 = f; start2 = 1'b1; end
        else            begin mode1 = mode; func1 = f; start1 = 1'b1; end
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        chk({tag, "_busy"}, 32'(o_busy), 1);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            // A stray start mid-run must be ignored.
            if (cycles == 5) begin start1 = (which == 1); start2 = (which == 2); end
            if (cycles == 6) begin start1 = 1'b0; start2 = 1'b0; end
        end while (!o_done && cycles < 100);
        chk({tag, "_latency"}, 32'(cycles), 32'(lat));
        check_result(which, tag);
    endtask

    initial begin
        int cycles;
        int dcount;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state(1, "rst1");
        check_reset_state(2, "rst2");
        rst_n = 1'b1;

        run(1, 0, FN_OR,  "or_ok");
        run(1, 1, FN_OR,  "stuck0");
        run(1, 0, FN_AND, "and_vs_or");
        run(1, 0, FN_NOR, "nor_vs_or");

        // Reset while the third vector is being held.
        sel = 1;
        @(negedge clk);
        mode1 = 0; func1 = FN_OR; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cycles = 0;
        while (s1 != 2'd2 && cycles < 50) begin @(negedge clk); cycles++; end
        chk("midrst_reach_stim2", 32'(s1), 2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_state(1, "midrst");
        dcount = 0;
        repeat (20) begin @(negedge clk); if (done1) dcount++; end
        chk("midrst_no_done", 32'(dcount), 0);
        run(1, 0, FN_OR, "after_rst");

        // Leave a nonzero count, then hold start high with a correct XOR gate.
        run(1, 1, FN_OR, "pre_hold");
        sel = 1;
        mode1 = 2; func1 = FN_XOR;
        for (int r = 0; r < 3; r++) sb.push_back(predict(2, FN_XOR, 2, 255));
        start1 = 1'b1;
        for (int r = 0; r < 3; r++) begin
            cycles = 0;
            do begin @(negedge clk); cycles++; end while (!busy1 && cycles < 20);
            chk("hold_busy_rise", 32'(busy1), 1);
            cycles = 0;
            do begin
                @(negedge clk);
                cycles++;
                if (r == 0 && cycles == 4) func1 = FN_AND;
                if (r == 0 && cycles == 8) func1 = FN_XOR;
            end while (!done1 && cycles < 100);
            chk("hold_latency", 32'(cycles), 12);
            check_result(1, "hold_xor");
        end
        start1 = 1'b0;
        repeat (3) @(negedge clk);

        run(2, 3, FN_OR,  "sat_inv");
        run(2, 2, FN_XOR, "n3_xor_ok");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
        $fatal(1, "timeout");
    end

endmodule
